// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache with its miss FSM.
// Hits complete in the request cycle; misses stall while lines move over the mem_* handshake.
module dcache_ctrl #(
   parameter int LINES  = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p1_req_i,
   input  logic              p1_write_i,
   input  logic [31:0]       p1_addr_i,
   input  logic [31:0]       p1_data_i,
   output logic [31:0]       p1_data_o,
   output logic              p1_stall_o,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   output logic [31:0]       mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   input  logic              mem_ack_i
);
   localparam int OFF_W  = $clog2(LINE_W / 8);
   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_W  = 32 - IDX_W - OFF_W;
   localparam int WSEL_W = OFF_W - 2;

   typedef enum logic [2:0] {IDLE, MISS, WRITEBACK, READMISS, READMISSOK} state_t;

   state_t              state_q;
   logic [LINES-1:0]    valid_q;
   logic [LINES-1:0]    dirty_q;
   logic [TAG_W-1:0]    tag_q  [LINES];
   logic [LINE_W-1:0]   data_q [LINES];

   logic                mem_enable_q;
   logic                mem_write_q;
   logic [31:0]         mem_addr_q;
   logic [LINE_W-1:0]   mem_data_q;

   logic [TAG_W-1:0]    req_tag;
   logic [IDX_W-1:0]    req_idx;
   logic [WSEL_W-1:0]   req_word;
   logic                hit;
   logic                store_hit;
   logic                fill;
   logic                unused_addr_bits;

   assign req_tag          = p1_addr_i[31 -: TAG_W];
   assign req_idx          = p1_addr_i[OFF_W +: IDX_W];
   assign req_word         = p1_addr_i[2 +: WSEL_W];
   assign unused_addr_bits = ^p1_addr_i[1:0];

   assign hit       = p1_req_i && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   // Stores are only serviced from IDLE, so a refilled store lands one cycle after READMISSOK.
   assign store_hit = (state_q == IDLE) && hit && p1_write_i;
   assign fill      = (state_q == READMISS) && mem_ack_i;

   assign p1_data_o    = hit ? data_q[req_idx][{req_word, 5'b00000} +: 32] : '0;
   assign p1_stall_o   = (state_q != IDLE) || (p1_req_i && !hit);
   assign mem_enable_o = mem_enable_q;
   assign mem_write_o  = mem_write_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_data_o   = mem_data_q;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q      <= IDLE;
         mem_enable_q <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_data_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (p1_req_i && !hit) state_q <= MISS;
            end
            MISS: begin
               mem_enable_q <= 1'b1;
               if (valid_q[req_idx] && dirty_q[req_idx]) begin
                  state_q     <= WRITEBACK;
                  mem_write_q <= 1'b1;
                  mem_addr_q  <= {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
                  mem_data_q  <= data_q[req_idx];
               end else begin
                  state_q     <= READMISS;
                  mem_write_q <= 1'b0;
                  mem_addr_q  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                  mem_data_q  <= '0;
               end
            end
            WRITEBACK: begin
               if (mem_ack_i) begin
                  state_q     <= READMISS;
                  mem_write_q <= 1'b0;
                  mem_addr_q  <= {req_tag, req_idx, {OFF_W{1'b0}}};
                  mem_data_q  <= '0;
               end
            end
            READMISS: begin
               if (mem_ack_i) begin
                  state_q      <= READMISSOK;
                  mem_enable_q <= 1'b0;
                  mem_addr_q   <= '0;
               end
            end
            READMISSOK: state_q <= IDLE;
            default:    state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (fill) begin
         valid_q[req_idx] <= 1'b1;
         dirty_q[req_idx] <= 1'b0;
      end else if (store_hit) begin
         dirty_q[req_idx] <= 1'b1;
      end
   end

   // Tag/data arrays carry no reset; reset only suppresses writes so an aborted fill leaves no trace.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         if (fill) begin
            data_q[req_idx] <= mem_data_i;
            tag_q[req_idx]  <= req_tag;
         end else if (store_hit) begin
            data_q[req_idx][{req_word, 5'b00000} +: 32] <= p1_data_i;
         end
      end
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a cycle-counting memory responder inside a linear step sequence.
module tb_dcache_ctrl;
   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;
   logic         p1_req_i = 1'b0;
   logic         p1_write_i = 1'b0;
   logic [31:0]  p1_addr_i = '0;
   logic [31:0]  p1_data_i = '0;
   logic [31:0]  p1_data_o;
   logic         p1_stall_o;
   logic         mem_enable_o;
   logic         mem_write_o;
   logic [31:0]  mem_addr_o;
   logic [255:0] mem_data_o;
   logic [255:0] mem_data_i = '0;
   logic         mem_ack_i = 1'b0;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [255:0] mem_line [0:2047];
   int           mw_cycles;
   int           wb_acks;
   logic [31:0]  last_wb_addr;
   logic [255:0] last_wb_data;
   logic [31:0]  last_fill_addr;

   dcache_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .p1_req_i(p1_req_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
      .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] mk_line(input logic [31:0] base);
      logic [255:0] l;
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = base + k;
      return l;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Called at posedge+1; holds the request until the first unstalled cycle, answering the
   // memory handshake with an ack in the n-th enabled cycle of each transfer.
   task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input int n, output int stall_cnt, output logic [31:0] rdata);
      int  cnt;
      bit  done;
      cnt = 0; done = 0; stall_cnt = 0; rdata = '0;
      mw_cycles = 0;
      p1_req_i = 1'b1; p1_write_i = wr; p1_addr_i = a; p1_data_i = d;
      for (int cyc = 0; cyc < 300; cyc++) begin
         #4;
         if (!p1_stall_o) begin
            rdata = p1_data_o;
            done = 1;
            break;
         end
         stall_cnt++;
         if (mem_write_o) mw_cycles++;
         if (mem_enable_o) begin
            cnt++;
            if (cnt == n) begin
               cnt = 0;
               mem_ack_i = 1'b1;
               if (mem_write_o) begin
                  wb_acks++;
                  last_wb_addr = mem_addr_o;
                  last_wb_data = mem_data_o;
                  mem_line[mem_addr_o[15:5]] = mem_data_o;
               end else begin
                  last_fill_addr = mem_addr_o;
                  mem_data_i = mem_line[mem_addr_o[15:5]];
               end
            end
         end
         tick();
         mem_ack_i = 1'b0;
      end
      chk("access_completes", 256'(done), 256'(1));
      tick();
      p1_req_i = 1'b0; p1_write_i = 1'b0;
   endtask

   initial begin
      int           st;
      logic [31:0]  rd;
      logic [255:0] exp_line;

      for (int i = 0; i < 2048; i++) mem_line[i] = '0;
      mem_line[11'h002] = {32'h07070707, 32'h06060606, 32'h05050505, 32'h04040404,
                           32'h03030303, 32'h02020202, 32'hDEADBEEF, 32'h00000000};
      mem_line[11'h022] = mk_line(32'hA000_0000);
      mem_line[11'h008] = mk_line(32'hB000_0000);
      mem_line[11'h028] = mk_line(32'hE000_0000);
      mem_line[11'h062] = mk_line(32'hD000_0000);
      wb_acks = 0; last_wb_addr = '0; last_wb_data = '0; last_fill_addr = '0;

      // Reset held for two cycles
      rst_i = 1'b0;
      repeat (2) @(posedge clk_i);
      #1; #4;
      chk("rst_mem_enable", 256'(mem_enable_o), 256'(0));
      chk("rst_mem_write",  256'(mem_write_o),  256'(0));
      chk("rst_mem_addr",   256'(mem_addr_o),   256'(0));
      chk("rst_mem_data",   mem_data_o,         256'(0));
      chk("rst_stall",      256'(p1_stall_o),   256'(0));
      chk("rst_p1_data",    256'(p1_data_o),    256'(0));
      tick();
      rst_i = 1'b1;
      p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h0000_0040;
      #4;
      chk("rst_then_miss_stall", 256'(p1_stall_o), 256'(1));
      tick();
      p1_req_i = 1'b0; rst_i = 1'b0;
      tick();
      rst_i = 1'b1;
      #4;
      chk("rst_abort_miss_enable", 256'(mem_enable_o), 256'(0));
      chk("rst_abort_miss_stall",  256'(p1_stall_o),   256'(0));
      tick();

      // Cold load miss, N = 10
      access(1'b0, 32'h0000_0044, 32'h0, 10, st, rd);
      chk("cold_stall",      256'(st),             256'(13));
      chk("cold_data",       256'(rd),             256'(32'hDEADBEEF));
      chk("cold_no_write",   256'(mw_cycles),      256'(0));
      chk("cold_fill_addr",  256'(last_fill_addr), 256'(32'h0000_0040));

      // Store hit, then dirty eviction with N = 4
      access(1'b1, 32'h0000_0048, 32'hCAFEF00D, 10, st, rd);
      chk("store_hit_stall", 256'(st), 256'(0));
      access(1'b0, 32'h0000_0448, 32'h0, 4, st, rd);
      exp_line = {32'h07070707, 32'h06060606, 32'h05050505, 32'h04040404,
                  32'h03030303, 32'hCAFEF00D, 32'hDEADBEEF, 32'h00000000};
      chk("evict_stall",     256'(st),             256'(11));
      chk("evict_wb_count",  256'(wb_acks),        256'(1));
      chk("evict_wb_addr",   256'(last_wb_addr),   256'(32'h0000_0040));
      chk("evict_wb_word2",  256'(last_wb_data[95:64]), 256'(32'hCAFEF00D));
      chk("evict_wb_line",   last_wb_data,         exp_line);
      chk("evict_fill_addr", 256'(last_fill_addr), 256'(32'h0000_0440));
      chk("evict_data",      256'(rd),             256'(32'hA000_0002));

      // Store miss (write-allocate), N = 1
      access(1'b1, 32'h0000_0100, 32'h12345678, 1, st, rd);
      chk("stmiss_stall",     256'(st), 256'(4));
      chk("stmiss_no_wb",     256'(wb_acks), 256'(1));
      access(1'b0, 32'h0000_0100, 32'h0, 1, st, rd);
      chk("stmiss_load_stall", 256'(st), 256'(0));
      chk("stmiss_load_data",  256'(rd), 256'(32'h12345678));
      access(1'b0, 32'h0000_0500, 32'h0, 2, st, rd);
      exp_line = mk_line(32'hB000_0000);
      exp_line[31:0] = 32'h12345678;
      chk("stmiss_evict_stall", 256'(st),           256'(7));
      chk("stmiss_evict_addr",  256'(last_wb_addr), 256'(32'h0000_0100));
      chk("stmiss_evict_line",  last_wb_data,       exp_line);
      chk("stmiss_evict_data",  256'(rd),           256'(32'hE000_0000));

      // Spurious ack in IDLE
      mem_ack_i = 1'b1;
      #4;
      chk("idle_ack_enable", 256'(mem_enable_o), 256'(0));
      chk("idle_ack_stall",  256'(p1_stall_o),   256'(0));
      tick();
      mem_ack_i = 1'b0;
      #4;
      chk("idle_ack_after_enable", 256'(mem_enable_o), 256'(0));
      tick();
      access(1'b0, 32'h0000_0448, 32'h0, 1, st, rd);
      chk("idle_ack_hit_stall", 256'(st), 256'(0));
      chk("idle_ack_hit_data",  256'(rd), 256'(32'hA000_0002));

      // Acks held through IDLE and MISS, then first READMISS cycle
      mem_data_i = mk_line(32'hC000_0000);
      p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h0000_0840; mem_ack_i = 1'b1;
      #4;
      chk("early_idle_stall",  256'(p1_stall_o),   256'(1));
      chk("early_idle_enable", 256'(mem_enable_o), 256'(0));
      tick();
      #4;
      chk("early_miss_enable", 256'(mem_enable_o), 256'(0));
      chk("early_miss_stall",  256'(p1_stall_o),   256'(1));
      tick();
      #4;
      chk("early_rm_enable", 256'(mem_enable_o), 256'(1));
      chk("early_rm_write",  256'(mem_write_o),  256'(0));
      chk("early_rm_addr",   256'(mem_addr_o),   256'(32'h0000_0840));
      tick();
      mem_ack_i = 1'b0;
      #4;
      chk("early_rmok_enable", 256'(mem_enable_o), 256'(0));
      chk("early_rmok_stall",  256'(p1_stall_o),   256'(1));
      tick();
      #4;
      chk("early_idle_hit_stall", 256'(p1_stall_o), 256'(0));
      chk("early_idle_hit_data",  256'(p1_data_o),  256'(32'hC000_0000));
      tick();
      p1_req_i = 1'b0;

      // Reset during READMISS
      p1_req_i = 1'b1; p1_write_i = 1'b0; p1_addr_i = 32'h0000_0C44;
      tick();
      tick();
      #4;
      chk("midfill_enable_before", 256'(mem_enable_o), 256'(1));
      tick();
      rst_i = 1'b0; p1_req_i = 1'b0;
      tick();
      rst_i = 1'b1;
      #4;
      chk("midfill_enable_after", 256'(mem_enable_o), 256'(0));
      chk("midfill_stall_after",  256'(p1_stall_o),   256'(0));
      tick();
      access(1'b0, 32'h0000_0C44, 32'h0, 3, st, rd);
      chk("midfill_reissue_stall", 256'(st), 256'(6));
      chk("midfill_reissue_data",  256'(rd), 256'(32'hD000_0001));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
